imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the RYSY core. It extracts and sign- or zero-extends the immediate field from a raw instruction word according to a decoded immediate type. Output is registered, with a valid/ready handshake and a one-entry skid buffer. It sits between the decoder and the ALU/branch operand mux, replacing the purely combinational immediate select.

---
 rtl/imm_gen_pkg.sv | 24 ++
 rtl/imm_extract.sv | 39 +++
 rtl/imm_gen_pipe.sv | 125 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: type codes, widths and FSM states.
// IMM_ZICSR_EN (optional define) makes IMM_Z a legal immediate type.
package imm_gen_pkg;

  localparam int REG_LEN      = 32;
  localparam int IMM_TYPE_LEN = 3;

  typedef logic [IMM_TYPE_LEN-1:0] imm_type_t;

  localparam imm_type_t IMM_NONE = 3'd0;
  localparam imm_type_t IMM_I    = 3'd1;
  localparam imm_type_t IMM_S    = 3'd2;
  localparam imm_type_t IMM_B    = 3'd3;
  localparam imm_type_t IMM_U    = 3'd4;
  localparam imm_type_t IMM_J    = 3'd5;
  localparam imm_type_t IMM_Z    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
// IMM_ZICSR_EN: when defined, IMM_Z yields the zero-extended CSR zimm field.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = REG_LEN
) (
  input  logic [31:0]             instr,
  input  logic [IMM_TYPE_LEN-1:0] imm_type,
  output logic [XLEN-1:0]         imm,
  output logic                    illegal
);

  // Every format is first built as a correctly signed 32-bit value, then widened.
  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_NONE: raw = '0;
      IMM_I:    raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:    raw = {instr[31:12], 12'b0};
      IMM_J:    raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      IMM_Z:    raw = {27'b0, instr[19:15]};
`endif
      default:  illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and optional one-entry skid buffer.
// IMM_ZICSR_EN (optional define, see imm_extract) enables the CSR zimm type.
//
// state   | meaning
// IDLE    | output and skid empty
// BUSY    | output full, skid empty
// FULL    | output and skid full, input stalled
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = REG_LEN,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             instr,
  input  logic [IMM_TYPE_LEN-1:0] imm_type,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         imm,
  output logic [IMM_TYPE_LEN-1:0] out_type,
  output logic                    illegal
);

  state_t                  state_q, state_d;
  logic [XLEN-1:0]         ext_imm;
  logic                    ext_ill;
  logic [XLEN-1:0]         skid_imm;
  logic [IMM_TYPE_LEN-1:0] skid_type;
  logic                    skid_ill;
  logic                    in_fire, out_fire;
  logic                    load_out_in, load_out_skid, load_skid;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (instr),
    .imm_type (imm_type),
    .imm      (ext_imm),
    .illegal  (ext_ill)
  );

  assign out_valid = (state_q != ST_IDLE);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_fire) begin
          state_d     = ST_BUSY;
          load_out_in = 1'b1;
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_out_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_IDLE;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end
        end
        ST_FULL: if (out_fire) begin
          state_d       = ST_BUSY;
          load_out_skid = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm       <= '0;
      out_type  <= '0;
      illegal   <= 1'b0;
      skid_imm  <= '0;
      skid_type <= '0;
      skid_ill  <= 1'b0;
    end else begin
      if (load_out_in) begin
        imm      <= ext_imm;
        out_type <= imm_type;
        illegal  <= ext_ill;
      end else if (load_out_skid) begin
        imm      <= skid_imm;
        out_type <= skid_type;
        illegal  <= skid_ill;
      end
      if (load_skid) begin
        skid_imm  <= ext_imm;
        skid_type <= imm_type;
        skid_ill  <= ext_ill;
      end
    end
  end

  // Without a skid buffer FULL is unreachable: ready drops whenever BUSY is stalled.
  generate
    if (SKID_EN) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b1;
        else        ready_q <= (state_d != ST_FULL);
      end
      assign in_ready = ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances in lockstep).
// Expected zimm behaviour follows IMM_ZICSR_EN.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_type;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;
  logic [2:0]  out_type;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  out_type64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_type(imm_type), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .out_type(out_type), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_type(imm_type), .out_valid(out_valid64), .out_ready(out_ready),
    .imm(imm64), .out_type(out_type64), .illegal(illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] t);
    in_valid = v;
    instr    = i;
    imm_type = t;
  endtask

  logic [31:0] bb_instr [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123450B7, 32'hFF9FF06F};
  logic [2:0]  bb_type  [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [31:0] bb_exp   [4] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8};

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_out_type", 64'(out_type), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // I-type, single result, both widths
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 3'd1);
    step();
    drive(1'b0, 32'h0, 3'd0);
    chk("i_valid", 64'(out_valid), 64'd1);
    chk("i_imm32", 64'(imm), 64'h00000000FFFFFFFF);
    chk("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("i_illegal", 64'(illegal), 64'd0);
    chk("i_type", 64'(out_type), 64'd1);
    step();
    chk("i_drain", 64'(out_valid), 64'd0);

    // back-to-back stream
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, bb_instr[k], bb_type[k]);
      step();
      chk($sformatf("bb_imm%0d", k), 64'(imm), 64'(bb_exp[k]));
      chk($sformatf("bb_type%0d", k), 64'(out_type), 64'(bb_type[k]));
      chk($sformatf("bb_rdy%0d", k), 64'(in_ready), 64'd1);
      chk($sformatf("bb_vld%0d", k), 64'(out_valid), 64'd1);
    end
    chk("u_imm64", imm64, 64'hFFFFFFFFFFFFFFF8);
    drive(1'b0, 32'h0, 3'd0);
    step();
    chk("bb_drain", 64'(out_valid), 64'd0);

    // backpressure: third entry must wait for the skid to drain
    out_ready = 1'b0;
    drive(1'b1, 32'h0020A423, 3'd2);
    step();
    chk("bp_rdy_a", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h123450B7, 3'd4);
    step();
    chk("bp_rdy_full", 64'(in_ready), 64'd0);
    chk("bp_hold_a", 64'(imm), 64'd8);
    drive(1'b1, 32'hFF9FF06F, 3'd5);
    step();
    chk("bp_stall_rdy", 64'(in_ready), 64'd0);
    chk("bp_stall_imm", 64'(imm), 64'd8);
    chk("bp_stall_vld", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_res_b", 64'(imm), 64'h12345000);
    chk("bp_rdy_b", 64'(in_ready), 64'd1);
    step();
    chk("bp_res_c", 64'(imm), 64'hFFFFFFF8);
    chk("bp_type_c", 64'(out_type), 64'd5);
    drive(1'b0, 32'h0, 3'd0);
    step();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // flush while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd1);
    step();
    drive(1'b1, 32'h0020A423, 3'd2);
    step();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'hFE000EE3, 3'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_vld", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h123450B7, 3'd4);
    step();
    drive(1'b0, 32'h0, 3'd0);
    chk("fl_next_vld", 64'(out_valid), 64'd1);
    chk("fl_next_imm", 64'(imm), 64'h12345000);
    out_ready = 1'b1;
    step();
    chk("fl_drain", 64'(out_valid), 64'd0);

    // reserved, zimm and none types
    drive(1'b1, 32'hFFFFFFFF, 3'd7);
    step();
    chk("r7_imm", 64'(imm), 64'd0);
    chk("r7_ill", 64'(illegal), 64'd1);
    chk("r7_type", 64'(out_type), 64'd7);
    drive(1'b1, 32'h0002D073, 3'd6);
    step();
`ifdef IMM_ZICSR_EN
    chk("z_imm", 64'(imm), 64'd5);
    chk("z_ill", 64'(illegal), 64'd0);
`else
    chk("z_imm", 64'(imm), 64'd0);
    chk("z_ill", 64'(illegal), 64'd1);
`endif
    drive(1'b1, 32'hFFFFFFFF, 3'd0);
    step();
    chk("none_imm", 64'(imm), 64'd0);
    chk("none_ill", 64'(illegal), 64'd0);

    // asynchronous reset mid-transfer
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd1);
    step();
    drive(1'b0, 32'h0, 3'd0);
    chk("ar_pre_vld", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(out_valid), 64'd0);
    chk("ar_imm", 64'(imm), 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_rdy", 64'(in_ready), 64'd1);
    chk("ar_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
